// File: rtl/id_stage_if.sv
// Decode-stage bus: the IF/ID instruction, hazard/write-back inputs and the
// control word, register indices, operands and immediate sent to ID/EX.
interface id_stage_if;
   logic [31:0] instr_in;
   logic        flush;
   logic        ex_mem_read;
   logic [4:0]  ex_rd;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   logic        mem_to_reg;
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic        beq_instruction;
   logic        aluSrc;
   logic [1:0]  aluOp;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] imediato;
   logic        stall;

   // Pipeline side: feeds the decode stage and consumes its results.
   modport master (
      output instr_in, flush, ex_mem_read, ex_rd, wb_reg_write, wb_rd, wb_data,
      input  mem_to_reg, reg_write, mem_read, mem_write, beq_instruction,
             aluSrc, aluOp, rs1, rs2, rd, rs1_data, rs2_data, imediato, stall
   );

   // Decode stage itself.
   modport slave (
      input  instr_in, flush, ex_mem_read, ex_rd, wb_reg_write, wb_rd, wb_data,
      output mem_to_reg, reg_write, mem_read, mem_write, beq_instruction,
             aluSrc, aluOp, rs1, rs2, rd, rs1_data, rs2_data, imediato, stall
   );
endinterface

// File: rtl/id_stage.sv
// RV32I-subset instruction decode: register file with write-through bypass,
// control decoder, immediate generator and load-use hazard detection.
module id_stage (
   input logic       clk,
   input logic       reset,
   id_stage_if.slave bus
);

   typedef enum logic [6:0] {
      OP_R   = 7'b0110011,
      OP_I   = 7'b0010011,
      OP_LW  = 7'b0000011,
      OP_SW  = 7'b0100011,
      OP_BEQ = 7'b1100011
   } opcode_e;

   logic [31:0] regs [32];
   logic [31:0] instr;
   logic [4:0]  rs1_idx;
   logic [4:0]  rs2_idx;
   logic        uses_rs1;
   logic        uses_rs2;
   logic        hazard;
   logic        bubble;
   logic [7:0]  ctrl_raw;

   assign instr   = bus.instr_in;
   assign rs1_idx = instr[19:15];
   assign rs2_idx = instr[24:20];

   assign bus.rs1 = rs1_idx;
   assign bus.rs2 = rs2_idx;
   assign bus.rd  = instr[11:7];

   // Register file: asynchronous clear, write on rising edge, x0 never written.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (bus.wb_reg_write && (bus.wb_rd != 5'd0)) begin
         regs[bus.wb_rd] <= bus.wb_data;
      end
   end

   // Operand reads with x0 hardwired to zero and same-cycle write-back bypass.
   always_comb begin
      bus.rs1_data = '0;
      bus.rs2_data = '0;
      if (rs1_idx != 5'd0) begin
         if (bus.wb_reg_write && (bus.wb_rd == rs1_idx)) begin
            bus.rs1_data = bus.wb_data;
         end else begin
            bus.rs1_data = regs[rs1_idx];
         end
      end
      if (rs2_idx != 5'd0) begin
         if (bus.wb_reg_write && (bus.wb_rd == rs2_idx)) begin
            bus.rs2_data = bus.wb_data;
         end else begin
            bus.rs2_data = regs[rs2_idx];
         end
      end
   end

   // Opcode decode: raw control word {mem_to_reg, reg_write, mem_read,
   // mem_write, beq, aluSrc, aluOp}, operand usage and immediate.
   always_comb begin
      ctrl_raw     = '0;
      uses_rs1     = 1'b0;
      uses_rs2     = 1'b0;
      bus.imediato = '0;
      case (instr[6:0])
         OP_R: begin
            ctrl_raw = 8'b0100_0010;
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         OP_I: begin
            ctrl_raw     = 8'b0100_0111;
            uses_rs1     = 1'b1;
            bus.imediato = {{20{instr[31]}}, instr[31:20]};
         end
         OP_LW: begin
            ctrl_raw     = 8'b1110_0100;
            uses_rs1     = 1'b1;
            bus.imediato = {{20{instr[31]}}, instr[31:20]};
         end
         OP_SW: begin
            ctrl_raw     = 8'b0001_0100;
            uses_rs1     = 1'b1;
            uses_rs2     = 1'b1;
            bus.imediato = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         OP_BEQ: begin
            ctrl_raw     = 8'b0000_1001;
            uses_rs1     = 1'b1;
            uses_rs2     = 1'b1;
            bus.imediato = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
         end
         default: ;
      endcase
   end

   // Load-use hazard against the load sitting in ID/EX; stall or flush bubbles.
   always_comb begin
      hazard = 1'b0;
      if (bus.ex_mem_read && (bus.ex_rd != 5'd0)) begin
         hazard = (uses_rs1 && (bus.ex_rd == rs1_idx)) ||
                  (uses_rs2 && (bus.ex_rd == rs2_idx));
      end
      bubble = hazard || bus.flush;
   end

   assign bus.stall = hazard;

   assign {bus.mem_to_reg, bus.reg_write, bus.mem_read, bus.mem_write,
           bus.beq_instruction, bus.aluSrc, bus.aluOp} = bubble ? 8'd0 : ctrl_raw;

   // funct3 is not needed by this decoder; folded away so the bits are consumed.
   logic unused_funct3;
   assign unused_funct3 = ^instr[14:12];

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage RV32I subset pipeline. It sits between the IF/ID pipeline register and the ID/EX pipeline register. It owns the 32×32 register file, the main control decoder, the immediate generator and load-use hazard detection. It produces the control word, register indices, operands and immediate that the ID/EX register latches on the next rising edge.

## Interface
Parameters:
- none (XLEN fixed at 32, 32 architectural registers)

Ports:
- clk  in  1  clock; register file writes on rising edge
- reset  in  1  asynchronous, active-high; clears the register file
- instr_in  in  32  instruction from IF/ID
- flush  in  1  taken-branch flush from EX/MEM; forces a bubble
- ex_mem_read  in  1  mem_read of the instruction currently in ID/EX
- ex_rd  in  5  rd of the instruction currently in ID/EX
- wb_reg_write  in  1  write-back enable from MEM/WB
- wb_rd  in  5  write-back destination
- wb_data  in  32  write-back value
- mem_to_reg, reg_write, mem_read, mem_write, beq_instruction, aluSrc  out  1 each  control word to ID/EX
- aluOp  out  2  00 add (lw/sw), 01 sub (beq), 10 R-type funct, 11 I-type ALU funct
- rs1, rs2, rd  out  5 each  instr_in[19:15], [24:20], [11:7]
- rs1_data, rs2_data  out  32  register operands
- imediato  out  32  sign-extended immediate
- stall  out  1  load-use stall; freezes PC and IF/ID

## Operation
- Decode by opcode (instr_in[6:0]):
  - 0110011 R: reg_write=1, aluOp=10.
  - 0010011 I-ALU: reg_write=1, aluSrc=1, aluOp=11.
  - 0000011 lw: reg_write=1, mem_read=1, mem_to_reg=1, aluSrc=1, aluOp=00.
  - 0100011 sw: mem_write=1, aluSrc=1, aluOp=00.
  - 1100011 beq: beq_instruction=1, aluOp=01.
  - Any other opcode: all control outputs 0.
- Immediate:
  - I-type/lw: sext(instr[31:20]).
  - sw: sext({instr[31:25], instr[11:7]}).
  - beq: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - R-type and other opcodes: 0.
- Register file:
  - x0 reads 0 and is never written.
  - Write at posedge clk when wb_reg_write=1 and wb_rd≠0.
- Write-through bypass: if wb_reg_write=1, wb_rd≠0 and wb_rd equals the read index, rs*_data = wb_data in that same cycle.
- Hazard:
  - rs2 counts as used only for R, sw and beq.
  - stall=1 when ex_mem_read=1, ex_rd≠0 and (ex_rd==rs1 for a non-default opcode, or ex_rd==rs2 when rs2 is used).
- Bubble: when stall=1 or flush=1, all seven control outputs are forced to 0. rs1/rs2/rd/imediato/data still reflect instr_in.
- stall is not asserted because of flush. flush and stall together produce a bubble with stall=1.

## Timing
- Decode, immediate, hazard and register reads are combinational, with zero-cycle latency from instr_in. Outputs are valid before the edge that loads ID/EX.
- Register write commits on the rising edge and is visible in the same cycle through the bypass.
- reset asserted: all 32 registers become 0 immediately (asynchronous). rs1_data/rs2_data read 0 unless the bypass is active. Other outputs remain combinational in instr_in.
- reset mid-operation: a write in the reset cycle is discarded.
- Load-use stall lasts exactly one cycle, because ID/EX then holds a bubble with mem_read=0.

## Test plan
- Reset, then instr_in=0x00000013 (addi x0,x0,0): rs1_data=0, imediato=0, reg_write=1, aluSrc=1, aluOp=11, stall=0.
- wb_reg_write=1, wb_rd=5, wb_data=0xDEADBEEF with instr_in=add x1,x5,x5 (0x005280B3): rs1_data=rs2_data=0xDEADBEEF in the same cycle. After the edge with wb_reg_write=0, the value is still 0xDEADBEEF.
- Write x0 with 0x1234: rs1_data for rs1=0 stays 0 before and after the edge.
- sw x2,-4(x1) (0xFE20AE23): imediato=0xFFFFFFFC, mem_write=1, aluSrc=1. beq x1,x2,-8 (0xFE208CE3): imediato=0xFFFFFFF8, beq_instruction=1, aluOp=01.
- ex_mem_read=1, ex_rd=3, instr_in=add x4,x3,x0: stall=1, all control 0. Same with instr_in=addi x4,x6,3 (rs2 field=3, unused): stall=0. ex_rd=0: stall=0.
- flush=1 with lw x7,8(x1): all control 0, stall=0, imediato=8. Assert reset while wb_reg_write=1 to x9: x9 reads 0 afterward.
